lbl_pack: RTL and testbench

LBL_PACK -- requirements
Module: lbl_pack

---
 rtl/lbl_pack_if.sv | 20 ++
 rtl/lbl_pack.sv | 102 ++++++++++
 tb/tb_lbl_pack.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/lbl_pack_if.sv
// Label-map SRAM port and packed-byte output handshake of lbl_pack.
interface lbl_pack_if;
  logic [9:0] sram_a;
  logic       sram_wen;
  logic [7:0] sram_q;
  logic [7:0] out_data;
  logic [6:0] out_addr;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output sram_a, sram_wen, out_data, out_addr, out_valid,
    input  sram_q, out_ready
  );

  modport slave (
    input  sram_a, sram_wen, out_data, out_addr, out_valid,
    output sram_q, out_ready
  );
endinterface

// File: rtl/lbl_pack.sv
// Packs a 32x32 label map into 128 one-bit-per-pixel mask bytes for a selected label.
// Optional LBL_PACK_AREA_EN adds an 11-bit matching-pixel count output "area".
module lbl_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  sel_label,
  output logic        busy,
  output logic        finish,
  lbl_pack_if.master  bus
`ifdef LBL_PACK_AREA_EN
  ,
  output logic [10:0] area
`endif
);

  typedef enum logic [2:0] {IDLE, SCAN, LAST, EMIT, DONE} state_t;

  state_t     state, state_nx;
  logic [2:0] k;
  logic [7:0] sel_q;
  logic [7:1] shreg;
  logic [7:0] data_q;
  logic [6:0] addr_q;
  logic       match;

  assign match = (sel_q != 8'd0) ? (bus.sram_q == sel_q) : (bus.sram_q != 8'd0);

  // k parks at 7 outside SCAN, so the address holds its last value without a separate register
  assign bus.sram_a    = {addr_q, k};
  assign bus.sram_wen  = 1'b1;
  assign bus.out_data  = data_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_valid = (state == EMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = SCAN;
      end
      SCAN: if (k == 3'd7) state_nx = LAST;
      LAST: state_nx = EMIT;
      EMIT: if (bus.out_ready) state_nx = (addr_q == 7'd127) ? DONE : SCAN;
      DONE: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k      <= '0;
      sel_q  <= '0;
      shreg  <= '0;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sel_q  <= sel_label;
          addr_q <= '0;
          k      <= '0;
        end
        SCAN: begin
          // read data lags the address by one cycle: at step k it belongs to pixel k-1
          if (k != 3'd0) shreg[3'd0 - k] <= match;
          if (k != 3'd7) k <= k + 3'd1;
        end
        LAST: data_q <= {shreg, match};
        EMIT: if (bus.out_ready && addr_q != 7'd127) begin
          addr_q <= addr_q + 7'd1;
          k      <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef LBL_PACK_AREA_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      area <= '0;
    end else if (state == IDLE && start) begin
      area <= '0;
    end else if (((state == SCAN && k != 3'd0) || state == LAST) && match) begin
      area <= area + 11'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lbl_pack.sv
// Directed self-checking bench for lbl_pack with a synchronous-read label-map model.
module tb_lbl_pack;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] sel_label;
  logic       busy;
  logic       finish;
`ifdef LBL_PACK_AREA_EN
  logic [10:0] area;
`endif

  lbl_pack_if bus ();

  lbl_pack dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sel_label (sel_label),
    .busy      (busy),
    .finish    (finish),
    .bus       (bus)
`ifdef LBL_PACK_AREA_EN
    ,
    .area      (area)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  always @(posedge clk) bus.sram_q <= mem[bus.sram_a];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int b, input logic [7:0] sel);
    logic [7:0] r;
    logic [7:0] v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      v = mem[b*8 + i];
      r[7-i] = (sel != 8'd0) ? (v == sel) : (v != 8'd0);
    end
    return r;
  endfunction

  function automatic int exp_area(input logic [7:0] sel);
    int n;
    n = 0;
    for (int p = 0; p < 1024; p++)
      if ((sel != 8'd0) ? (mem[p] == sel) : (mem[p] != 8'd0)) n++;
    return n;
  endfunction

  int         nb, lat_first, fin_edge, stall_seen, stall_bad;
  logic [7:0] got_data [128];
  logic [6:0] got_addr [128];

  // One pass: optional ready stall on a byte, optional start poke while busy, optional abort by reset.
  task automatic run_pass(input logic [7:0] sel, input int stall_byte,
                          input int poke_edge, input int abort_byte);
    int         e, stall_left, vld_cnt;
    logic       done;
    logic [7:0] hd;
    logic [6:0] ha;
    logic [9:0] hsa;
    nb = 0; lat_first = -1; fin_edge = -1; stall_seen = 0; stall_bad = 0;
    stall_left = 5; hd = '0; ha = '0; hsa = '0; done = 1'b0;
    bus.out_ready = 1'b1;
    sel_label = sel;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0;
    while (!done && e < 3000) begin
      start = (e == poke_edge);
      if (e == poke_edge) sel_label = 8'h01;
      bus.out_ready = 1'b1;
      if (bus.out_valid) begin
        if (nb == abort_byte) begin
          reset = 1'b1;
          #1;
          check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
          check("rst_busy", {31'd0, busy}, 32'd0);
          check("rst_data", {24'd0, bus.out_data}, 32'd0);
          check("rst_addr", {25'd0, bus.out_addr}, 32'd0);
          check("rst_sram_a", {22'd0, bus.sram_a}, 32'd0);
          @(posedge clk); #1;
          reset = 1'b0;
          vld_cnt = 0;
          for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid || busy) vld_cnt++;
          end
          check("abort_quiet", vld_cnt, 32'd0);
          done = 1'b1;
          break;
        end else if (nb == stall_byte && stall_left > 0) begin
          bus.out_ready = 1'b0;
          if (stall_left == 5) begin
            hd = bus.out_data; ha = bus.out_addr; hsa = bus.sram_a;
          end else if (bus.out_data !== hd || bus.out_addr !== ha || bus.sram_a !== hsa) begin
            stall_bad++;
          end
          stall_left--;
          stall_seen++;
        end else begin
          if (nb == stall_byte &&
              (bus.out_data !== hd || bus.out_addr !== ha || bus.sram_a !== hsa)) stall_bad++;
          if (nb < 128) begin
            got_data[nb] = bus.out_data;
            got_addr[nb] = bus.out_addr;
          end
          if (nb == 0) lat_first = e + 1;
          nb++;
        end
      end
      if (finish) begin
        fin_edge = e + 1;
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      e++;
    end
    start = 1'b0;
    check("pass_done", {31'd0, done}, 32'd1);
    if (fin_edge >= 0) begin
      @(posedge clk); #1;
      check("finish_1cyc", {31'd0, finish}, 32'd0);
      check("idle_after", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic verify_pass(input string tag, input logic [7:0] sel);
    check({tag, "_nbytes"}, nb, 32'd128);
    for (int b = 0; b < 128 && b < nb; b++) begin
      check({tag, "_data"}, {24'd0, got_data[b]}, {24'd0, exp_byte(b, sel)});
      check({tag, "_addr"}, {25'd0, got_addr[b]}, b);
    end
  endtask

  initial begin
    for (int p = 0; p < 1024; p++) mem[p] = 8'd0;
    reset = 1'b1; start = 1'b0; sel_label = 8'd0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_finish", {31'd0, finish}, 32'd0);
    check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_data", {24'd0, bus.out_data}, 32'd0);
    check("reset_addr", {25'd0, bus.out_addr}, 32'd0);
    check("reset_sram_a", {22'd0, bus.sram_a}, 32'd0);
    check("sram_wen", {31'd0, bus.sram_wen}, 32'd1);
`ifdef LBL_PACK_AREA_EN
    check("reset_area", {21'd0, area}, 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    // all-zero map, any-label select
    run_pass(8'd0, -1, -1, -1);
    verify_pass("zero", 8'd0);
    check("zero_first_xfer_edge", lat_first, 32'd10);
    check("zero_finish_edge", fin_edge, 32'd1281);
`ifdef LBL_PACK_AREA_EN
    check("zero_area", {21'd0, area}, 32'd0);
`endif

    // label 3 at pixels 0, 7, 1023
    mem[0] = 8'd3; mem[7] = 8'd3; mem[1023] = 8'd3;
    run_pass(8'd3, -1, -1, -1);
    verify_pass("lbl3", 8'd3);
    check("lbl3_byte0", {24'd0, got_data[0]}, 32'h81);
    check("lbl3_byte127", {24'd0, got_data[127]}, 32'h01);
`ifdef LBL_PACK_AREA_EN
    check("lbl3_area", {21'd0, area}, 32'd3);
`endif

    // row 0 mixed labels 1/2; second start with another label mid-pass must be ignored
    for (int p = 0; p < 1024; p++) mem[p] = 8'd0;
    for (int i = 0; i < 32; i++) mem[i] = (i % 3 == 0) ? 8'd1 : ((i % 3 == 1) ? 8'd2 : 8'd0);
    run_pass(8'd0, -1, 25, -1);
    verify_pass("mix_any", 8'd0);
    check("mix_any_byte0", {24'd0, got_data[0]}, 32'hDB);
    check("mix_any_finish_edge", fin_edge, 32'd1281);
`ifdef LBL_PACK_AREA_EN
    check("mix_any_area", {21'd0, area}, exp_area(8'd0));
`endif

    // label 2 only, with a 5-cycle ready stall on byte 4
    run_pass(8'd2, 4, -1, -1);
    verify_pass("mix_l2", 8'd2);
    check("mix_l2_byte0", {24'd0, got_data[0]}, 32'h49);
    check("stall_cycles", stall_seen, 32'd5);
    check("stall_stable", stall_bad, 32'd0);
    check("stall_finish_edge", fin_edge, 32'd1286);

    // reset while byte 60 is offered, then a fresh full pass
    for (int p = 0; p < 1024; p++) mem[p] = 8'd0;
    mem[0] = 8'd3; mem[7] = 8'd3; mem[1023] = 8'd3;
    run_pass(8'd3, -1, -1, 60);
    check("abort_bytes_before", nb, 32'd60);
    run_pass(8'd3, -1, -1, -1);
    verify_pass("restart", 8'd3);
    check("restart_first_addr", {25'd0, got_addr[0]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
